// File: rtl/bram_burst_intf.sv
// bram_burst_intf: burst read front-end for a synchronous BRAM.
// A request (start address, length) is turned into one BRAM read per cycle.
// The reads travel through a READ_LATENCY-deep tag pipeline and land in a
// skid FIFO whose head is a registered valid/ready stream stage.
// A credit counter (FIFO_DEPTH = READ_LATENCY+2) limits in-flight plus
// buffered words, so backpressure never loses data.
//
// Ports:
//   clk, rst (async, active-low)
//   req_addr/req_len/req_valid/req_ready : burst request (ready only in IDLE)
//   bram_addr/bram_en/bram_dout          : BRAM read port
//   data_out/data_valid/data_ready/data_last : output stream
//   busy : request accepted and not yet fully delivered
//   err  : one-cycle pulse on a rejected request
//
// Build option: BRAM_INTF_WRAP_EN lets bursts wrap past BRAM_DEPTH-1 to 0.
// Without it, bursts crossing the end of the BRAM are rejected.
module bram_burst_intf #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned BRAM_DEPTH   = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_BURST    = 256,
  parameter int unsigned ADDR_WIDTH   = $clog2(BRAM_DEPTH),
  parameter int unsigned LEN_WIDTH    = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  data_last,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned FIFO_DEPTH = READ_LATENCY + 2;
  localparam int unsigned CRED_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned SUM_W      = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic [CRED_W-1:0]       credits_q;
  logic [CRED_W-1:0]       cred_nxt_c;
  logic                    bram_last_q;
  logic [READ_LATENCY-1:0] sr_v;
  logic [READ_LATENCY-1:0] sr_l;

  entry_t                  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CRED_W-1:0]       mem_cnt;
  entry_t                  out_q;

  logic accept_c, reject_c, issue_c, bad_c, len_bad_c;
  logic pop_c, push_c, load_c, from_mem_c, direct_c, wr_c;
  entry_t push_entry_c;
`ifndef BRAM_INTF_WRAP_EN
  logic range_bad_c;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stream / FIFO handshake decode
  assign pop_c        = data_valid & data_ready;
  assign push_c       = sr_v[READ_LATENCY-1];
  assign push_entry_c = '{last: sr_l[READ_LATENCY-1], data: bram_dout};
  assign load_c       = !data_valid || pop_c;
  assign from_mem_c   = load_c && (mem_cnt != '0);
  assign direct_c     = load_c && (mem_cnt == '0) && push_c;
  assign wr_c         = push_c && !direct_c;
  assign data_out     = out_q.data;
  assign data_last    = out_q.last;

  // Credits as they will stand after this edge; an issue needs one left over.
  assign cred_nxt_c = credits_q - CRED_W'(bram_en) + CRED_W'(pop_c);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and control decode
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    reject_c  = 1'b0;
    issue_c   = 1'b0;
    len_bad_c = (req_len == '0) || (req_len > LEN_WIDTH'(MAX_BURST));
`ifdef BRAM_INTF_WRAP_EN
    bad_c = len_bad_c;
`else
    range_bad_c = (SUM_W'(req_addr) + SUM_W'(req_len)) > SUM_W'(BRAM_DEPTH);
    bad_c       = len_bad_c || range_bad_c;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (bad_c) begin
            reject_c = 1'b1;
          end else begin
            accept_c = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if ((rem_q != '0) && (cred_nxt_c != '0)) begin
          issue_c = 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last-tagged word is always the final one out of the FIFO.
        if (pop_c && data_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request, issue, credit and in-flight tag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      err         <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      bram_en     <= 1'b0;
      bram_addr   <= '0;
      bram_last_q <= 1'b0;
      credits_q   <= CRED_W'(FIFO_DEPTH);
      sr_v        <= '0;
      sr_l        <= '0;
    end else begin
      req_ready   <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
      err         <= reject_c;
      credits_q   <= cred_nxt_c;
      bram_en     <= issue_c;
      bram_last_q <= issue_c && (rem_q == LEN_WIDTH'(1));
      if (accept_c) begin
        addr_q <= req_addr;
        rem_q  <= req_len;
      end else if (issue_c) begin
        bram_addr <= addr_q;
        addr_q    <= (addr_q == ADDR_WIDTH'(BRAM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        rem_q     <= rem_q - LEN_WIDTH'(1);
      end
      // Tag enters on the edge the BRAM samples bram_en, emerges with its data.
      sr_v[0] <= bram_en;
      sr_l[0] <= bram_last_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_l[i] <= sr_l[i-1];
      end
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= push_entry_c;
  end

  // FIFO pointers and registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      out_q      <= '0;
      data_valid <= 1'b0;
    end else begin
      if (wr_c) wr_ptr <= ptr_inc(wr_ptr);
      if (from_mem_c) begin
        out_q      <= mem[rd_ptr];
        rd_ptr     <= ptr_inc(rd_ptr);
        data_valid <= 1'b1;
      end else if (direct_c) begin
        out_q      <= push_entry_c;
        data_valid <= 1'b1;
      end else if (load_c) begin
        out_q      <= '0;
        data_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + CRED_W'(wr_c) - CRED_W'(from_mem_c);
    end
  end

endmodule
